// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
package regfile_write_arbiter_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;
    localparam int unsigned NUM_REQ    = 3;
    localparam int unsigned PTR_W      = 2;

    localparam logic [REG_ADDR_W-1:0] SP_REG_IDX   = 5'd2;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG_IDX = 5'd0;
    localparam logic [REG_ADDR_W-1:0] LAST_REG_IDX = 5'd31;
    localparam logic [REG_ADDR_W-1:0] FIRST_REG_IDX = 5'd1;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } rf_write_t;

    // Pointer value that follows a grant to requester idx.
    function automatic logic [PTR_W-1:0] next_ptr(input int unsigned idx);
        return (idx >= NUM_REQ - 1) ? PTR_W'(0) : PTR_W'(idx + 1);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter3.sv
// Combinational 3-way round-robin grant, searching upward from rr_ptr_i.
module rr_arbiter3
    import regfile_write_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_c
);

    logic [2:0] idx;
    logic       found;

    always_comb begin
        grant_c = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < 3; k++) begin
            idx = 3'(rr_ptr_i) + 3'(k);
            if (idx >= 3'(NUM_REQ)) begin
                idx = idx - 3'(NUM_REQ);
            end
            if (!found && valid_i[idx[1:0]]) begin
                grant_c[idx[1:0]] = 1'b1;
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates three register-file write ports and runs a register clear sweep
// (x1..x31, x2 loaded with SP_INIT) on command or after reset.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter logic [31:0] SP_INIT        = 32'h00001000,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                            clk_in,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*REG_ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*REG_DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic                            clear_start,
    output logic                            clear_busy,
    output logic                            clear_done,
    output logic                            rf_reg_write,
    output logic [REG_ADDR_W-1:0]           rf_write_register,
    output logic [REG_DATA_W-1:0]           rf_data_to_write
);

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [REG_ADDR_W-1:0] cnt_q, cnt_d;
    rf_write_t             rf_q, rf_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  init_clr_q;

    logic                  clear_req;
    logic                  arb_en;
    logic [NUM_REQ-1:0]    grant;

    // The post-reset sweep is a one-shot synthetic clear_start.
    assign clear_req = clear_start | init_clr_q;
    assign arb_en    = !reset && (state_q == ST_ARB) && !clear_req;

    rr_arbiter3 u_rr_arbiter3 (
        .valid_i  (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .grant_c  (grant)
    );

    assign req_ready = arb_en ? grant : '0;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        rf_d     = rf_q;
        rf_d.we  = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        unique case (state_q)
            ST_ARB: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = FIRST_REG_IDX;
                end else begin
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (grant[i]) begin
                            rr_ptr_d = next_ptr(i);
                            // Writes to x0 are consumed but never reach the file.
                            if (req_addr[i*REG_ADDR_W +: REG_ADDR_W] != ZERO_REG_IDX) begin
                                rf_d.we   = 1'b1;
                                rf_d.addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                                rf_d.data = req_data[i*REG_DATA_W +: REG_DATA_W];
                            end
                        end
                    end
                end
            end
            ST_CLEAR: begin
                rf_d.we   = 1'b1;
                rf_d.addr = cnt_q;
                rf_d.data = (cnt_q == SP_REG_IDX) ? SP_INIT : '0;
                busy_d    = 1'b1;
                if (cnt_q == LAST_REG_IDX) begin
                    done_d  = 1'b1;
                    state_d = ST_ARB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + REG_ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= ST_ARB;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            rf_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            init_clr_q <= CLEAR_ON_RESET;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            rf_q       <= rf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            init_clr_q <= 1'b0;
        end
    end

    assign rf_reg_write      = rf_q.we;
    assign rf_write_register = rf_q.addr;
    assign rf_data_to_write  = rf_q.data;
    assign clear_busy        = busy_q;
    assign clear_done        = done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed table, corner sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_regfile_write_arbiter;

    localparam logic [31:0] SP = 32'h00001000;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        clear_start;
    logic        clear_busy;
    logic        clear_done;
    logic        rf_reg_write;
    logic [4:0]  rf_write_register;
    logic [31:0] rf_data_to_write;

    always #5 clk_in = ~clk_in;

    regfile_write_arbiter #(
        .SP_INIT        (SP),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk_in            (clk_in),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_data          (req_data),
        .req_ready         (req_ready),
        .clear_start       (clear_start),
        .clear_busy        (clear_busy),
        .clear_done        (clear_done),
        .rf_reg_write      (rf_reg_write),
        .rf_write_register (rf_write_register),
        .rf_data_to_write  (rf_data_to_write)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: plain integers and flags.
    int          m_ptr   = 0;
    bit          m_sweep = 1'b0;
    int          m_k     = 0;
    bit          m_init  = 1'b0;
    bit          m_we    = 1'b0;
    logic [4:0]  m_addr  = '0;
    logic [31:0] m_data  = '0;
    bit          m_busy  = 1'b0;
    bit          m_done  = 1'b0;

    typedef struct {
        logic [2:0]  valid;
        logic [14:0] addr;
        logic [95:0] data;
        logic [2:0]  exp_ready;
        logic        exp_we;
        bit          chk_addr;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of intended behaviour; rdy is the acceptance for this cycle.
    task automatic model_step(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                              input bit cs, input bit rst, output logic [2:0] rdy);
        rdy = '0;
        if (rst) begin
            m_ptr = 0; m_sweep = 0; m_k = 0; m_init = 1;
            m_we = 0; m_addr = '0; m_data = '0; m_busy = 0; m_done = 0;
        end else if (m_sweep) begin
            m_we   = 1;
            m_addr = 5'(m_k);
            m_data = (m_k == 2) ? SP : 32'd0;
            m_busy = 1;
            m_done = (m_k == 31);
            m_k++;
            if (m_k > 31) m_sweep = 0;
            m_init = 0;
        end else if (cs || m_init) begin
            m_sweep = 1; m_k = 1; m_init = 0;
            m_we = 0; m_busy = 0; m_done = 0;
        end else begin
            m_we = 0; m_busy = 0; m_done = 0;
            for (int j = 0; j < 3; j++) begin
                int i;
                i = (m_ptr + j) % 3;
                if (v[i]) begin
                    rdy[i] = 1'b1;
                    m_ptr  = (i + 1) % 3;
                    if (a[5*i +: 5] != 5'd0) begin
                        m_we   = 1;
                        m_addr = a[5*i +: 5];
                        m_data = d[32*i +: 32];
                    end
                    break;
                end
            end
        end
    endtask

    task automatic step(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                        input bit cs, input bit rst, output logic [2:0] rdy_obs);
        logic [2:0] er;
        req_valid   = v;
        req_addr    = a;
        req_data    = d;
        clear_start = cs;
        reset       = rst;
        #1;
        model_step(v, a, d, cs, rst, er);
        rdy_obs = req_ready;
        check("req_ready", 32'(req_ready), 32'(er));
        @(posedge clk_in);
        #1;
        check("rf_reg_write", 32'(rf_reg_write), 32'(m_we));
        check("clear_busy", 32'(clear_busy), 32'(m_busy));
        check("clear_done", 32'(clear_done), 32'(m_done));
        if (m_we) begin
            check("rf_write_register", 32'(rf_write_register), 32'(m_addr));
            check("rf_data_to_write", rf_data_to_write, m_data);
        end
    endtask

    // Idle cycles that tally sweep writes and check their ordering.
    task automatic run_sweep(input int n, input int cs_at, output int nw, output int nd);
        logic [2:0] r;
        int ea;
        nw = 0; nd = 0; ea = 1;
        for (int j = 0; j < n; j++) begin
            step('0, '0, '0, (j == cs_at), 1'b0, r);
            if (rf_reg_write) begin
                nw++;
                check("sweep_addr", 32'(rf_write_register), 32'(ea));
                check("sweep_data", rf_data_to_write, (ea == 2) ? SP : 32'd0);
                check("sweep_done_pos", 32'(clear_done), 32'(ea == 31));
                ea++;
            end
            if (clear_done) nd++;
        end
    endtask

    initial begin
        logic [2:0] r;
        int nw, nd, hit;

        tbl[0] = '{3'b111, {5'd6, 5'd4, 5'd3}, {32'hC2C20002, 32'hB1B10001, 32'hA0A00000}, 3'b001, 1'b1, 1'b1, 5'd3, 32'hA0A00000};
        tbl[1] = '{3'b111, {5'd6, 5'd4, 5'd3}, {32'hC2C20002, 32'hB1B10001, 32'hA0A00000}, 3'b010, 1'b1, 1'b1, 5'd4, 32'hB1B10001};
        tbl[2] = '{3'b111, {5'd6, 5'd4, 5'd3}, {32'hC2C20002, 32'hB1B10001, 32'hA0A00000}, 3'b100, 1'b1, 1'b1, 5'd6, 32'hC2C20002};
        tbl[3] = '{3'b111, {5'd6, 5'd4, 5'd3}, {32'hC2C20002, 32'hB1B10001, 32'hA0A00000}, 3'b001, 1'b1, 1'b1, 5'd3, 32'hA0A00000};
        tbl[4] = '{3'b111, {5'd6, 5'd4, 5'd3}, {32'hC2C20002, 32'hB1B10001, 32'hA0A00000}, 3'b010, 1'b1, 1'b1, 5'd4, 32'hB1B10001};
        tbl[5] = '{3'b111, {5'd6, 5'd4, 5'd3}, {32'hC2C20002, 32'hB1B10001, 32'hA0A00000}, 3'b100, 1'b1, 1'b1, 5'd6, 32'hC2C20002};
        tbl[6] = '{3'b001, {5'd6, 5'd4, 5'd0}, {32'hC2C20002, 32'hB1B10001, 32'hDEADBEEF}, 3'b001, 1'b0, 1'b0, 5'd0, 32'h0};
        tbl[7] = '{3'b011, {5'd6, 5'd9, 5'd7}, {32'hC2C20002, 32'h99990009, 32'h77770007}, 3'b010, 1'b1, 1'b1, 5'd9, 32'h99990009};
        tbl[8] = '{3'b000, {5'd6, 5'd9, 5'd7}, {32'hC2C20002, 32'h99990009, 32'h77770007}, 3'b000, 1'b0, 1'b1, 5'd9, 32'h99990009};

        // Reset values.
        for (int j = 0; j < 3; j++) step('0, '0, '0, 1'b0, 1'b1, r);
        check("rst_addr", 32'(rf_write_register), 32'd0);
        check("rst_data", rf_data_to_write, 32'd0);

        // Automatic sweep after reset release.
        run_sweep(34, -1, nw, nd);
        check("auto_sweep_writes", 32'(nw), 32'd31);
        check("auto_sweep_dones", 32'(nd), 32'd1);

        // Directed table: rotation, x0 drop, hold on idle.
        for (int t = 0; t < 9; t++) begin
            step(tbl[t].valid, tbl[t].addr, tbl[t].data, 1'b0, 1'b0, r);
            check("tbl_ready", 32'(r), 32'(tbl[t].exp_ready));
            check("tbl_we", 32'(rf_reg_write), 32'(tbl[t].exp_we));
            if (tbl[t].chk_addr) begin
                check("tbl_addr", 32'(rf_write_register), 32'(tbl[t].exp_addr));
                check("tbl_data", rf_data_to_write, tbl[t].exp_data);
            end
        end

        // clear_start concurrent with a request: request waits out the sweep.
        step(3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'h12345678, 32'd0}, 1'b1, 1'b0, r);
        check("cs_blocks_ready", 32'(r), 32'd0);
        hit = -1; nd = 0;
        for (int j = 0; j < 32; j++) begin
            step(3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'h12345678, 32'd0}, 1'b0, 1'b0, r);
            if (clear_done) nd++;
            if (hit < 0 && rf_reg_write && rf_write_register == 5'd5 && rf_data_to_write == 32'h12345678)
                hit = j;
        end
        check("pending_write_slot", 32'(hit), 32'd31);
        check("pending_sweep_dones", 32'(nd), 32'd1);

        // Re-pulsed clear_start mid-sweep is ignored.
        step('0, '0, '0, 1'b1, 1'b0, r);
        run_sweep(40, 9, nw, nd);
        check("repulse_writes", 32'(nw), 32'd31);
        check("repulse_dones", 32'(nd), 32'd1);

        // Reset mid-sweep aborts it; a fresh sweep follows release.
        step('0, '0, '0, 1'b1, 1'b0, r);
        for (int j = 0; j < 14; j++) step('0, '0, '0, 1'b0, 1'b0, r);
        step('0, '0, '0, 1'b0, 1'b1, r);
        check("abort_we", 32'(rf_reg_write), 32'd0);
        check("abort_busy", 32'(clear_busy), 32'd0);
        run_sweep(40, -1, nw, nd);
        check("fresh_sweep_writes", 32'(nw), 32'd31);
        check("fresh_sweep_dones", 32'(nd), 32'd1);

        // Randomized traffic against the model.
        for (int j = 0; j < 500; j++) begin
            logic [14:0] a;
            a = 15'($urandom);
            if ($urandom_range(0, 3) == 0) a[4:0] = 5'd0;
            step(3'($urandom_range(0, 7)), a, {$urandom, $urandom, $urandom},
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 199) == 0), r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk_in and reset, with all state changing only on the rising edge of clk_in.
REQ-002 Parameter SP_INIT, default 32'h00001000: the value written to x2 during a clear sweep.
REQ-003 Parameter CLEAR_ON_RESET, default 1: when 1, a clear sweep starts automatically after reset deasserts.
REQ-004 clk_in  input  1  system clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 req_valid  input  3  per-requester write request; requester i uses bit i.
REQ-007 req_addr  input  15  destination register; requester i uses bits [5i+4:5i].
REQ-008 req_data  input  96  write data; requester i uses bits [32i+31:32i].
REQ-009 req_ready  output  3  one-hot acceptance; a write transfers when req_valid[i] and req_ready[i] are both high.
REQ-010 clear_start  input  1  single-cycle command to start a clear sweep.
REQ-011 clear_busy  output  1  high while the clear sweep runs.
REQ-012 clear_done  output  1  one-cycle pulse on the final sweep write.
REQ-013 rf_reg_write  output  1  register-file write enable.
REQ-014 rf_write_register  output  5  register-file write address.
REQ-015 rf_data_to_write  output  32  register-file write data.

Function
REQ-016 The FSM SHALL have two states: ARB and CLEAR.
REQ-017 ARB: the block SHALL grant at most one valid requester per cycle, chosen round-robin starting from the pointer rr_ptr.
REQ-018 After each grant, rr_ptr SHALL move to (granted+1) mod 3. rr_ptr SHALL NOT change on cycles with no grant.
REQ-019 req_ready SHALL be combinational from req_valid, rr_ptr and state. It SHALL be zero whenever state is CLEAR or clear_start is high.
REQ-020 A grant SHALL register rf_reg_write=1 with the granted address and data on the next edge, giving 1-cycle latency, and rf_reg_write SHALL be held high for exactly one cycle.
REQ-021 A granted request to x0 SHALL be accepted and SHALL advance rr_ptr, but SHALL produce rf_reg_write=0 (write dropped).
REQ-022 No-grant cycles SHALL drive rf_reg_write=0. rf_write_register and rf_data_to_write SHALL hold their last values.
REQ-023 clear_start seen in ARB SHALL move the FSM to CLEAR at the next edge and load sweep counter cnt=1. No request is granted in that cycle.
REQ-024 CLEAR: one write per cycle, addresses 1..31 in order.
- Data is 0 for every address except x2, which gets SP_INIT.
- rf outputs are registered, so address k appears on the cycle after cnt=k.
REQ-025 A sweep SHALL take exactly 31 write cycles. clear_done SHALL pulse together with the write to x31, and the FSM SHALL return to ARB on that same edge.
REQ-026 clear_busy SHALL be high from the first sweep write through the x31 write, inclusive.
REQ-027 clear_start received while in CLEAR SHALL be ignored, with no restart and no queuing.
REQ-028 Requests held valid during CLEAR SHALL stay pending without loss. Arbitration SHALL resume from the unchanged rr_ptr on the first ARB cycle.
REQ-029 cnt SHALL be 5 bits and SHALL never wrap during a sweep. The terminal test is cnt==31.

Reset
REQ-030 While reset is high, the block SHALL hold:
- state=ARB, rr_ptr=0, cnt=0;
- rf_reg_write=0, rf_write_register=0, rf_data_to_write=0;
- clear_busy=0, clear_done=0, req_ready=0.
REQ-031 With CLEAR_ON_RESET=1, the first cycle after reset deasserts SHALL behave as if clear_start were high.
REQ-032 Reset asserted mid-sweep SHALL abort the sweep immediately. Reset asserted mid-grant SHALL cancel the pending registered write.

Structure
REQ-033 Shared package: the FSM state encoding, REG_ADDR_W=5, REG_DATA_W=32, NUM_REQ=3 and the constant SP_REG_IDX=5'd2.
REQ-034 One sub-module, rr_arbiter3, SHALL hold the combinational round-robin grant logic: it takes valid and rr_ptr and produces a one-hot grant. All other logic stays in regfile_write_arbiter.

Verification
REQ-035 Reset release with CLEAR_ON_RESET=1 -> 31 consecutive writes x1..x31; x2=32'h00001000 and all others 0; clear_done on the x31 cycle; req_ready=0 throughout.
REQ-036 All three valid continuously from rr_ptr=0 -> grants in order 0,1,2,0,1,2; each rf write appears 1 cycle after its handshake with the matching address/data.
REQ-037 req0 writes x0 with data 32'hDEADBEEF -> req_ready[0]=1, rf_reg_write stays 0, and the next grant goes to requester 1 when valid.
REQ-038 clear_start pulsed in the same cycle as req1 valid -> req_ready=0 that cycle; sweep runs; req1's write to x5 with data 32'h12345678 issues 1 cycle after the sweep ends.
REQ-039 clear_start re-pulsed at sweep cycle 10 -> sweep still ends after 31 writes with exactly one clear_done.
REQ-040 reset asserted at sweep cycle 15 -> next cycle rf_reg_write=0 and clear_busy=0; after release a full fresh 31-write sweep runs.
